stream_ft_buffer: RTL and testbench
===================================

Name: stream_ft_buffer

Overview:
- Parametrised multi-entry stream buffer with a ready/valid handshake on both sides; the generalised successor of the single-entry fall-through register.
- Depth is configurable. Fall-through mode (zero-latency forwarding when empty) and registered mode (one-cycle latency, no input-to-output combinational path) are selectable.
- Exports a fill-level count.
- Placed between stream producers and consumers to absorb back-pressure bursts without stalling the source.

Parameters:
- T, logic, payload type; width W = $bits(T).
- DEPTH, 2, number of storage entries; legal range >= 1, not required to be a power of two; elaboration fails for DEPTH < 1.
- FALL_THROUGH, 1'b1, 1 = forward data_i to data_o in the same cycle when empty; 0 = data appears one cycle after acceptance.
- CntWidth, $clog2(DEPTH+1), derived, width of usage_o; not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear; discards all stored entries.
- testmode_i  in  1  test mode; bypasses clock gating in storage.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- data_i  in  W  input payload.
- valid_o  out  1  output valid.
- ready_i  in  1  output ready.
- data_o  out  W  output payload.
- usage_o  out  CntWidth  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (rst_ni low, asynchronous): read pointer, write pointer and count go to 0. Outputs during and after reset: ready_o=1, valid_o=0 (FALL_THROUGH=0) or valid_o=valid_i (FALL_THROUGH=1), usage_o=0. Storage contents are not reset; data_o is don't-care while valid_o=0.
- Storage: circular buffer of DEPTH entries.
  - Pointers wrap from DEPTH-1 to 0 explicitly; no power-of-two modulo.
  - Count register: increments on store-only, decrements on pop-only, unchanged otherwise.
- ready_o = (count != DEPTH). It never depends on ready_i, so there is no ready_i->ready_o path. When full, no input is accepted even if the output pops in the same cycle.
- Input handshake: valid_i && ready_o.
- Output handshake: valid_o && ready_i.
- FALL_THROUGH=1, count==0:
  - valid_o=valid_i, data_o=data_i.
  - If both handshakes fire, the beat passes straight through: nothing stored, count stays 0.
  - If the input handshake fires without ready_i, data_i is written at the write pointer and count becomes 1.
- FALL_THROUGH=1, count>0: valid_o=1 and data_o=entry at the read pointer. The input is stored independently.
- FALL_THROUGH=0: valid_o=(count!=0) and data_o=entry at the read pointer always; minimum latency 1 cycle.
- Simultaneous push and pop with 0<count<DEPTH: write and read both occur, both pointers advance, count is unchanged.
- Ordering: strict FIFO; no beat dropped or duplicated.
- Stability: once valid_o=1 with count>0, valid_o and data_o hold until the output handshake or clr_i.
  - Exception, FALL_THROUGH=1 with count==0: valid_o follows the upstream, so the upstream is responsible for stability.
- clr_i (highest priority over push/pop in the same cycle):
  - Next cycle: pointers and count = 0.
  - Any push or pop in the clearing cycle is discarded; the handshake signals still reflect pre-clear state combinationally.
- Reset asserted mid-transfer: state returns to empty immediately; in-flight beats are lost. No X may propagate on ready_o, valid_o or usage_o.
- usage_o = count register; it is registered, so there is no combinational path from valid_i or ready_i.

Test Plan:
- Reset, then idle, DEPTH=2, FT=1 -> ready_o=1, valid_o=0, usage_o=0.
- FT=1, DEPTH=2, empty; valid_i=1, data_i=0xA5, ready_i=1 for one cycle -> same cycle valid_o=1, data_o=0xA5; next cycle usage_o=0.
- FT=0, DEPTH=3:
  - Push 0x11, 0x22, 0x33 with ready_i=0 -> usage_o=3, ready_o=0; a fourth beat 0x44 is held off.
  - Then ready_i=1 -> outputs 0x11, 0x22, 0x33 on consecutive cycles; ready_o returns to 1 the cycle after the first pop.
- DEPTH=3 (non-power-of-two), continuous push/pop for 10 beats 0..9 with ready_i toggling 1,0,1,... -> output order 0..9, pointers wrap correctly, usage_o never exceeds 3.
- Full buffer (DEPTH=2), valid_i=1 and ready_i=1 in the same cycle -> one pop, no push accepted (ready_o=0); next cycle usage_o=1.
- usage_o=2, clr_i=1 together with valid_i=1 and ready_i=1 -> next cycle usage_o=0, valid_o=0 (FT=0), and the pushed beat is never output.
- Reset pulse while usage_o=2 -> immediately usage_o=0, ready_o=1, valid_o=0; subsequent traffic is correct.

Source files
------------

// File: rtl/stream_ft_buffer.sv
// Multi-entry ready/valid stream buffer with selectable fall-through forwarding.
// Circular storage of DEPTH entries; usage_o reports the registered fill level.
module stream_ft_buffer #(
  parameter type T            = logic,
  parameter int  DEPTH        = 2,
  parameter bit  FALL_THROUGH = 1'b1,
  parameter int  CntWidth     = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                testmode_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic [CntWidth-1:0] usage_o
);

  if (DEPTH < 1) begin : gen_depth_check
    $error("stream_ft_buffer: DEPTH must be at least 1");
  end

  localparam int                  PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntWidth-1:0] CntFull  = CntWidth'(DEPTH);
  localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(DEPTH - 1);

  T                    mem_q [DEPTH];
  logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntWidth-1:0] count_q;

  logic empty;
  logic push_hs, pop_hs;
  logic bypass, store, pop;

  // Storage has no gated clock, so the test-mode override has nothing to act on.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    empty   = (count_q == '0);
    ready_o = (count_q != CntFull);
    valid_o = !empty;
    data_o  = mem_q[rd_ptr_q];
    if (FALL_THROUGH && empty) begin
      valid_o = valid_i;
      data_o  = data_i;
    end
    push_hs = valid_i && ready_o;
    pop_hs  = valid_o && ready_i;
    // An empty fall-through buffer hands a popped beat straight across without storing it.
    bypass  = FALL_THROUGH && empty && pop_hs;
    store   = push_hs && !bypass;
    pop     = pop_hs && !bypass;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (store && !pop)      count_q <= count_q + CntWidth'(1);
      else if (pop && !store) count_q <= count_q - CntWidth'(1);
    end
  end

  // NOTE: payload storage is deliberately not reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= data_i;
  end

  assign usage_o = count_q;

endmodule

// File: tb/tb_stream_ft_buffer.sv
// Scoreboard bench: a fall-through DEPTH=2 instance and a registered DEPTH=3 instance.
// Stimulus queues expected beats; per-instance monitors pop and compare on each output handshake.
module tb_stream_ft_buffer;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic testmode = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=2, fall-through
  logic       a_clr = 1'b0, a_valid = 1'b0, a_ready_i = 1'b0;
  byte_t      a_data = '0;
  logic       a_ready_o, a_valid_o;
  byte_t      a_data_o;
  logic [1:0] a_usage;

  // Instance B: DEPTH=3, registered
  logic       b_clr = 1'b0, b_valid = 1'b0, b_ready_i = 1'b0;
  byte_t      b_data = '0;
  logic       b_ready_o, b_valid_o;
  byte_t      b_data_o;
  logic [1:0] b_usage;

  stream_ft_buffer #(.T(byte_t), .DEPTH(2), .FALL_THROUGH(1'b1)) u_ft2 (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(a_clr), .testmode_i(testmode),
    .valid_i(a_valid), .ready_o(a_ready_o), .data_i(a_data),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .usage_o(a_usage)
  );

  stream_ft_buffer #(.T(byte_t), .DEPTH(3), .FALL_THROUGH(1'b0)) u_rg3 (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(b_clr), .testmode_i(testmode),
    .valid_i(b_valid), .ready_o(b_ready_o), .data_i(b_data),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .usage_o(b_usage)
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  byte_t exp_a[$];
  byte_t exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare on the falling edge when an output handshake is about to fire.
  always @(negedge clk) begin
    if (rst_ni && a_valid_o && a_ready_i) begin
      if (exp_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected_beat: got %0h, expected none", a_data_o);
      end else begin
        check("a_data", 32'(a_data_o), 32'(exp_a.pop_front()));
      end
    end
    if (rst_ni && b_valid_o && b_ready_i) begin
      if (exp_b.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected_beat: got %0h, expected none", b_data_o);
      end else begin
        check("b_data", 32'(b_data_o), 32'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    logic acc;

    // Reset state
    repeat (2) step();
    check("rst_a_ready", 32'(a_ready_o), 32'd1);
    check("rst_a_valid", 32'(a_valid_o), 32'd0);
    check("rst_a_usage", 32'(a_usage), 32'd0);
    check("rst_b_ready", 32'(b_ready_o), 32'd1);
    check("rst_b_valid", 32'(b_valid_o), 32'd0);
    check("rst_b_usage", 32'(b_usage), 32'd0);
    rst_ni = 1'b1;
    step();
    check("idle_a_valid", 32'(a_valid_o), 32'd0);
    check("idle_a_usage", 32'(a_usage), 32'd0);

    // Fall-through pass: beat visible in the same cycle, nothing stored
    a_valid = 1'b1; a_data = 8'hA5; a_ready_i = 1'b1;
    exp_a.push_back(8'hA5);
    #1;
    check("ft_same_cycle_valid", 32'(a_valid_o), 32'd1);
    check("ft_same_cycle_data", 32'(a_data_o), 32'hA5);
    step();
    a_valid = 1'b0; a_ready_i = 1'b0;
    check("ft_usage_after", 32'(a_usage), 32'd0);

    // Registered DEPTH=3 fill, fourth beat held off, then drain
    b_ready_i = 1'b0; b_valid = 1'b1;
    b_data = 8'h11; exp_b.push_back(8'h11); step();
    b_data = 8'h22; exp_b.push_back(8'h22); step();
    b_data = 8'h33; exp_b.push_back(8'h33); step();
    check("fill_usage_full", 32'(b_usage), 32'd3);
    check("fill_ready_low", 32'(b_ready_o), 32'd0);
    b_data = 8'h44; exp_b.push_back(8'h44);
    step();
    check("fill_44_held_usage", 32'(b_usage), 32'd3);
    b_ready_i = 1'b1;
    #1;
    check("fill_ready_low_at_pop", 32'(b_ready_o), 32'd0);
    step();
    check("fill_ready_back", 32'(b_ready_o), 32'd1);
    check("fill_usage_2", 32'(b_usage), 32'd2);
    step();
    b_valid = 1'b0;
    check("fill_usage_after_push_pop", 32'(b_usage), 32'd2);
    step();
    step();
    step();
    check("fill_drained_usage", 32'(b_usage), 32'd0);
    check("fill_drained_valid", 32'(b_valid_o), 32'd0);
    b_ready_i = 1'b0;

    // Non-power-of-two wrap: continuous push, alternating consumer ready
    for (int i = 0; i < 10; i++) exp_b.push_back(byte_t'(i));
    sent = 0;
    for (int k = 0; k < 60 && sent < 10; k++) begin
      b_valid = 1'b1;
      b_data = byte_t'(sent);
      b_ready_i = (k % 2 == 0);
      acc = b_ready_o;
      check("ring_usage_le3", 32'(b_usage > 2'd3), 32'd0);
      step();
      if (acc) sent++;
    end
    check("ring_all_sent", 32'(sent), 32'd10);
    b_valid = 1'b0;
    b_ready_i = 1'b1;
    for (int k = 0; k < 20 && exp_b.size() != 0; k++) step();
    check("ring_drained", 32'(exp_b.size()), 32'd0);
    step();
    check("ring_usage_zero", 32'(b_usage), 32'd0);
    b_ready_i = 1'b0;

    // Full DEPTH=2: simultaneous valid/ready pops one, accepts none
    a_ready_i = 1'b0; a_valid = 1'b1;
    a_data = 8'h01; exp_a.push_back(8'h01); step();
    a_data = 8'h02; exp_a.push_back(8'h02); step();
    check("full_usage_2", 32'(a_usage), 32'd2);
    a_data = 8'h03; a_ready_i = 1'b1;
    #1;
    check("full_ready_low", 32'(a_ready_o), 32'd0);
    check("full_valid_out", 32'(a_valid_o), 32'd1);
    check("full_head_data", 32'(a_data_o), 32'h01);
    step();
    a_valid = 1'b0;
    check("full_usage_1", 32'(a_usage), 32'd1);
    step();
    check("full_usage_0", 32'(a_usage), 32'd0);
    a_ready_i = 1'b0;

    // Clear with simultaneous push and pop
    b_ready_i = 1'b0; b_valid = 1'b1;
    b_data = 8'hAA; exp_b.push_back(8'hAA); step();
    b_data = 8'hBB; exp_b.push_back(8'hBB); step();
    check("clr_usage_2", 32'(b_usage), 32'd2);
    b_clr = 1'b1; b_data = 8'hCC; b_ready_i = 1'b1;
    #1;
    check("clr_ready_pre", 32'(b_ready_o), 32'd1);
    check("clr_valid_pre", 32'(b_valid_o), 32'd1);
    step();
    b_clr = 1'b0; b_valid = 1'b0;
    exp_b.delete();
    check("clr_usage_0", 32'(b_usage), 32'd0);
    check("clr_valid_0", 32'(b_valid_o), 32'd0);
    repeat (3) step();
    b_ready_i = 1'b0;

    // Asynchronous reset while holding two entries
    b_valid = 1'b1;
    b_data = 8'h55; exp_b.push_back(8'h55); step();
    b_data = 8'h66; exp_b.push_back(8'h66); step();
    b_valid = 1'b0;
    check("rstp_usage_2", 32'(b_usage), 32'd2);
    rst_ni = 1'b0;
    exp_b.delete();
    #1;
    check("rstp_usage_0", 32'(b_usage), 32'd0);
    check("rstp_ready_1", 32'(b_ready_o), 32'd1);
    check("rstp_valid_0", 32'(b_valid_o), 32'd0);
    step();
    rst_ni = 1'b1;
    step();

    // Traffic after reset
    b_valid = 1'b1; b_data = 8'h77; b_ready_i = 1'b1;
    exp_b.push_back(8'h77);
    a_valid = 1'b1; a_data = 8'h5A; a_ready_i = 1'b1;
    exp_a.push_back(8'h5A);
    step();
    b_valid = 1'b0; a_valid = 1'b0; a_ready_i = 1'b0;
    check("post_b_usage_1", 32'(b_usage), 32'd1);
    check("post_a_usage_0", 32'(a_usage), 32'd0);
    step();
    step();
    b_ready_i = 1'b0;
    check("post_b_usage_0", 32'(b_usage), 32'd0);
    check("end_exp_a_empty", 32'(exp_a.size()), 32'd0);
    check("end_exp_b_empty", 32'(exp_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
